// File: rtl/hd_8b10b_pkg.sv
// Shared 8b/10b code tables and constants, used by the transmit encoder and the receive decoder.
// Holds only RD- base codes; running-disparity complementing is applied by the encoder.
package hd_8b10b_pkg;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_DATA = 1'b1
    } tx_state_e;

    // Symbols are written abcdei_fghj with bit 9 = a.
    localparam logic [9:0] K_28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K_28_5_RDP = 10'b1100000101;

    localparam logic [3:0] CODE4_A7_RDN = 4'b0111;

    // 5b/6b base code (abcdei) at RD-; D.7 is the balanced 111000 variant.
    function automatic logic [5:0] code6_rdn(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b base code (fghj) at RD-; y=7 yields the primary P7 code.
    function automatic logic [3:0] code4_rdn(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // A7 replaces P7 where P7 would create a run of five equal bits across the sub-block seam.
    function automatic logic use_a7_rdn(input logic [4:0] x);
        return (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
    endfunction

    function automatic logic use_a7_rdp(input logic [4:0] x);
        return (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
    endfunction

    function automatic logic is_bal6(input logic [5:0] c);
        return $countones(c) == 3;
    endfunction

    function automatic logic is_bal4(input logic [3:0] c);
        return $countones(c) == 2;
    endfunction

endpackage

// File: rtl/hd_8b10b_enc_comb.sv
// Combinational 8b/10b symbol encoder: D.x.y or K.28.5 at a given running disparity.
// Produces the 10-bit symbol (bit 9 = a) and the running disparity after it.
module hd_8b10b_enc_comb
    import hd_8b10b_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       is_k_i,
    input  logic       rd_i,
    output logic [9:0] sym_o,
    output logic       rd_o
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] base6;
    logic [5:0] code6;
    logic [3:0] base4;
    logic [3:0] code4;
    logic       unbal6;
    logic       unbal4;
    logic       rd_mid;
    logic       rd_end;

    assign x = data_i[4:0];
    assign y = data_i[7:5];

    always_comb begin
        base6  = code6_rdn(x);
        unbal6 = !is_bal6(base6);
        code6  = (rd_i && (unbal6 || (x == 5'd7))) ? ~base6 : base6;
        rd_mid = unbal6 ? ~rd_i : rd_i;

        // The 4b sub-block is chosen against the disparity left by the 6b sub-block.
        if ((y == 3'd7) && ((!rd_mid && use_a7_rdn(x)) || (rd_mid && use_a7_rdp(x)))) begin
            base4 = CODE4_A7_RDN;
        end else begin
            base4 = code4_rdn(y);
        end
        unbal4 = !is_bal4(base4);
        code4  = (rd_mid && (unbal4 || (y == 3'd3))) ? ~base4 : base4;
        rd_end = unbal4 ? ~rd_mid : rd_mid;

        if (is_k_i) begin
            sym_o = rd_i ? K_28_5_RDP : K_28_5_RDN;
            rd_o  = ~rd_i;
        end else begin
            sym_o = {code6, code4};
            rd_o  = rd_end;
        end
    end

endmodule

// File: rtl/hd_8b10b_tx.sv
// 8b/10b transmitter: sync commas after reset, byte handshake, encode, serialize MSB (a) first.
// Optional periodic comma insertion is enabled by defining HD_8B10B_TX_COMMA_INSERT_EN.
module hd_8b10b_tx
    import hd_8b10b_pkg::*;
#(
    parameter int SYNC_SYMBOLS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx_out,
    output logic       symbol_start,
    output logic       rd_pos
);

    localparam logic [3:0] SYNC_INIT = 4'(SYNC_SYMBOLS);

    tx_state_e  state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] sync_cnt_q, sync_cnt_d;
    logic       rd_q, rd_d;
    logic       tx_q, tx_d;
    logic       start_q, start_d;
    logic [9:0] shreg_q, shreg_d;

    logic       load;
    logic       accept;
    logic       force_comma;
    logic [9:0] enc_sym;
    logic       enc_rd;

    assign load = (bit_cnt_q == 4'd9);

`ifdef HD_8B10B_TX_COMMA_INSERT_EN
    logic [4:0] data_cnt_q, data_cnt_d;

    assign force_comma = (data_cnt_q == 5'd16);

    always_comb begin
        data_cnt_d = data_cnt_q;
        if (load) begin
            data_cnt_d = accept ? data_cnt_q + 5'd1 : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_cnt_q <= 5'd0;
        end else begin
            data_cnt_q <= data_cnt_d;
        end
    end
`else
    assign force_comma = 1'b0;
`endif

    assign data_ready = (state_q == ST_DATA) && load && !force_comma;
    assign accept     = data_valid && data_ready;

    hd_8b10b_enc_comb u_enc (
        .data_i (data_in),
        .is_k_i (!accept),
        .rd_i   (rd_q),
        .sym_o  (enc_sym),
        .rd_o   (enc_rd)
    );

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        rd_d       = rd_q;
        bit_cnt_d  = load ? 4'd0 : bit_cnt_q + 4'd1;
        shreg_d    = {shreg_q[8:0], 1'b0};

        if (load) begin
            shreg_d = enc_sym;
            rd_d    = enc_rd;
            if (state_q == ST_SYNC) begin
                sync_cnt_d = sync_cnt_q - 4'd1;
                if (sync_cnt_q == 4'd1) begin
                    state_d = ST_DATA;
                end
            end
        end

        // tx_out is registered, so it follows the head of the next shift-register value.
        tx_d    = shreg_d[9];
        start_d = load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            bit_cnt_q  <= 4'd9;
            sync_cnt_q <= SYNC_INIT;
            rd_q       <= 1'b0;
            tx_q       <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
            start_q    <= start_d;
        end
    end

    // Shift register is pure data; the first edge after reset always loads it.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign tx_out       = tx_q;
    assign symbol_start = start_q;
    assign rd_pos       = rd_q;

endmodule

// File: tb/tb_hd_8b10b_tx.sv
// Scoreboard bench for hd_8b10b_tx: driver pushes hand-computed symbols, monitor deserializes and compares.
module tb_hd_8b10b_tx;

    localparam int SYNC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx_out;
    logic       symbol_start;
    logic       rd_pos;

    hd_8b10b_tx #(.SYNC_SYMBOLS(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .tx_out       (tx_out),
        .symbol_start (symbol_start),
        .rd_pos       (rd_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sym;
        logic       rd;
        logic [7:0] d;
        logic       is_data;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   sync_left = 0;
    int   dcnt = 0;
    logic m_rd = 1'b0;
    logic last_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed encodings for the bytes used by this bench at each starting RD.
    function automatic void ref_data(input logic [7:0] d, input logic rin,
                                     output logic [9:0] s, output logic rout);
        case ({rin, d})
            {1'b0, 8'h00}: begin s = 10'b1001110100; rout = 1'b0; end
            {1'b1, 8'h00}: begin s = 10'b0110001011; rout = 1'b1; end
            {1'b0, 8'hB5}: begin s = 10'b1010101010; rout = 1'b0; end
            {1'b1, 8'hB5}: begin s = 10'b1010101010; rout = 1'b1; end
            {1'b0, 8'hF1}: begin s = 10'b1000110111; rout = 1'b1; end
            {1'b1, 8'hF1}: begin s = 10'b1000110001; rout = 1'b0; end
            {1'b0, 8'hEB}: begin s = 10'b1101001110; rout = 1'b1; end
            {1'b1, 8'hEB}: begin s = 10'b1101001000; rout = 1'b0; end
            default:       begin s = 10'bxxxxxxxxxx; rout = 1'bx; end
        endcase
    endfunction

    function automatic void ref_k(input logic rin, output logic [9:0] s, output logic rout);
        s    = rin ? 10'b1100000101 : 10'b0011111010;
        rout = ~rin;
    endfunction

    // Called #1 after the edge that starts the bit_cnt==9 cycle.
    task automatic present(input logic v, input logic [7:0] d);
        exp_t       e;
        logic       exp_rdy;
        logic       forced;
        logic [9:0] s;
        logic       r;
        data_valid = v;
        data_in    = d;
        #1;
        forced = 1'b0;
`ifdef HD_8B10B_TX_COMMA_INSERT_EN
        forced = (dcnt == 16);
`endif
        if (sync_left > 0) begin
            exp_rdy = 1'b0;
            sync_left--;
        end else begin
            exp_rdy = !forced;
        end
        check("data_ready_at_load", 32'(data_ready), 32'(exp_rdy));
        e.is_data = v && exp_rdy;
        e.d       = d;
        if (e.is_data) begin
            ref_data(d, m_rd, s, r);
            dcnt++;
        end else begin
            ref_k(m_rd, s, r);
            dcnt = 0;
        end
        e.sym    = s;
        e.rd     = r;
        m_rd     = r;
        last_acc = e.is_data;
        q.push_back(e);
    endtask

    task automatic do_slot(input logic v, input logic [7:0] d, input logic hold);
        present(v, d);
        @(posedge clk); #1;
        data_valid = hold;
        data_in    = 8'h3C;
        check("data_ready_mid_symbol", 32'(data_ready), 32'd0);
        repeat (9) @(posedge clk);
        #1;
    endtask

    // Monitor: deserialize each symbol starting at symbol_start and compare against the queue head.
    int         mon_cnt = 0;
    logic [9:0] mon_sym = '0;
    logic       mon_rd = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_cnt = 0;
        end else if (symbol_start) begin
            check("symbol_spacing", 32'(mon_cnt), 32'd0);
            mon_sym[9] = tx_out;
            mon_rd     = rd_pos;
            mon_cnt    = 1;
        end else if (mon_cnt > 0) begin
            mon_sym[9 - mon_cnt] = tx_out;
            mon_cnt++;
            if (mon_cnt == 10) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_symbol: got %b expected none", mon_sym);
                end else begin
                    e = q.pop_front();
                    check(e.is_data ? "data_symbol" : "comma_symbol", 32'(mon_sym), 32'(e.sym));
                    check("rd_pos", 32'(mon_rd), 32'(e.rd));
                end
                mon_cnt = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && data_valid && data_ready) n_acc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] b2b [20] = '{8'hF1, 8'h00, 8'hB5, 8'hEB, 8'hF1, 8'hF1, 8'hEB, 8'h00,
                            8'hEB, 8'hB5, 8'h00, 8'hF1, 8'hB5, 8'h00, 8'hEB, 8'hEB,
                            8'hF1, 8'hB5, 8'h00, 8'hEB};

    initial begin
        int idx;
        int slots;
        int acc0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_out", 32'(tx_out), 32'd0);
        check("reset_symbol_start", 32'(symbol_start), 32'd0);
        check("reset_rd_pos", 32'(rd_pos), 32'd0);
        check("reset_data_ready", 32'(data_ready), 32'd0);
        rst       = 1'b0;
        sync_left = SYNC;
        m_rd      = 1'b0;
        dcnt      = 0;

        // Sync commas, then idle fill in DATA.
        for (int i = 0; i < SYNC + 2; i++) do_slot(1'b0, 8'h00, 1'b0);

        // Directed single bytes.
        do_slot(1'b1, 8'h00, 1'b0);
        do_slot(1'b1, 8'hB5, 1'b0);
        do_slot(1'b1, 8'hF1, 1'b0);
        do_slot(1'b1, 8'hEB, 1'b0);
        do_slot(1'b0, 8'h00, 1'b0);

        // Back-to-back with data_valid held high.
        acc0  = n_acc;
        idx   = 0;
        slots = 0;
        while (idx < 20 && slots < 40) begin
            do_slot(1'b1, b2b[idx], 1'b1);
            slots++;
            if (last_acc) idx++;
        end
        check("b2b_accepts", 32'(n_acc - acc0), 32'd20);
`ifdef HD_8B10B_TX_COMMA_INSERT_EN
        check("b2b_slots", 32'(slots), 32'd21);
`else
        check("b2b_slots", 32'(slots), 32'd20);
`endif
        do_slot(1'b0, 8'h00, 1'b0);

        // Mid-symbol reset while RD+ is on the line.
        if (m_rd != 1'b0) do_slot(1'b0, 8'h00, 1'b0);
        present(1'b1, 8'hF1);
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_rd_pos", 32'(rd_pos), 32'(m_rd));
        check("pre_reset_tx_out", 32'(tx_out), 32'd1);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        check("midreset_tx_out", 32'(tx_out), 32'd0);
        check("midreset_rd_pos", 32'(rd_pos), 32'd0);
        check("midreset_symbol_start", 32'(symbol_start), 32'd0);
        check("midreset_data_ready", 32'(data_ready), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        sync_left = SYNC;
        m_rd      = 1'b0;
        dcnt      = 0;
        for (int i = 0; i < SYNC; i++) do_slot(1'b0, 8'h00, 1'b0);
        do_slot(1'b1, 8'h00, 1'b0);

        @(negedge clk); #1;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
